// File: rtl/prbs_burst_ctrl_if.sv
// Host control plus PRBS word stream between burst sequencer and consumer.
// No logic: signal bundle only, latency not applicable.
// Stream side uses valid/ready; the consumer stalls the stream by holding out_ready low.
interface prbs_burst_ctrl_if #(
   parameter int LEN_W = 16
);
   logic             start;
   logic             abort;
   logic [6:0]       seed;
   logic [LEN_W-1:0] burst_len;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_data;
   logic             out_last;
   logic             busy;
   logic             done;
   logic             aborted;
   logic             seed_fixup;
   logic [LEN_W-1:0] words_sent;

   // Sequencer side: produces the stream and status.
   modport master (
      input  start, abort, seed, burst_len, out_ready,
      output out_valid, out_data, out_last, busy, done, aborted, seed_fixup, words_sent
   );

   // Host/consumer side: issues requests and accepts words.
   modport slave (
      output start, abort, seed, burst_len, out_ready,
      input  out_valid, out_data, out_last, busy, done, aborted, seed_fixup, words_sent
   );
endinterface

// File: rtl/prbs_burst_ctrl.sv
// Emits a seeded burst of burst_len 7-bit PRBS words (x^7+x^6+1) as 8-bit stream words.
// First word valid one cycle after start is accepted, then one word per cycle while ready.
// LFSR and counters hold while out_valid & !out_ready, so out_data/out_last stay stable.
module prbs_burst_ctrl #(
   parameter int LEN_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   prbs_burst_ctrl_if.master bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [6:0]       lfsr;
   logic [LEN_W-1:0] remaining;
   logic [LEN_W-1:0] words_sent;
   logic             aborted;
   logic             seed_fixup;

   logic             handshake;
   logic             final_word;
   logic [6:0]       lfsr_next;
   logic [6:0]       seed_load;

   // An all-zero seed would lock the LFSR, so it is replaced by 7'h01.
   assign seed_load  = (bus.seed == 7'd0) ? 7'h01 : bus.seed;
   assign lfsr_next  = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
   assign handshake  = (state == RUN) && bus.out_ready;
   assign final_word = (remaining == LEN_W'(1));

   // Burst FSM together with LFSR, word counters and sticky status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         lfsr       <= 7'h01;
         remaining  <= '0;
         words_sent <= '0;
         aborted    <= 1'b0;
         seed_fixup <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  seed_fixup <= (bus.seed == 7'd0);
                  aborted    <= 1'b0;
                  words_sent <= '0;
                  if (bus.burst_len != '0) begin
                     lfsr      <= seed_load;
                     remaining <= bus.burst_len;
                     state     <= RUN;
                  end else begin
                     state     <= DONE;
                  end
               end
            end
            RUN: begin
               if (handshake) begin
                  lfsr       <= lfsr_next;
                  remaining  <= remaining - LEN_W'(1);
                  words_sent <= words_sent + LEN_W'(1);
               end
               // Normal completion takes priority over a coincident abort.
               if (handshake && final_word) begin
                  state <= DONE;
               end else if (bus.abort) begin
                  aborted <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Outputs are pure decode of registered state; no input reaches an output combinationally.
   always_comb begin
      bus.out_valid  = (state == RUN);
      bus.out_data   = {lfsr[6], lfsr};
      bus.out_last   = (state == RUN) && final_word;
      bus.busy       = (state != IDLE);
      bus.done       = (state == DONE);
      bus.aborted    = aborted;
      bus.seed_fixup = seed_fixup;
      bus.words_sent = words_sent;
   end
endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// Directed self-checking bench for prbs_burst_ctrl.
// Inputs driven and outputs sampled on the falling edge, away from the active edge.
// Each scenario task carries its own inline comparisons.
module tb_prbs_burst_ctrl;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   prbs_burst_ctrl_if #(.LEN_W(16)) bus ();

   prbs_burst_ctrl #(.LEN_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-computed first words for seed 7'h01.
   logic [7:0] seq01 [0:7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'hC1, 8'h03};

   function automatic logic [6:0] lfsr_step(input logic [6:0] s);
      return {s[5:0], s[6] ^ s[5]};
   endfunction

   // Pulse start for one cycle; returns at the falling edge after acceptance.
   task automatic do_start(input logic [6:0] sd, input logic [15:0] len);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.seed      = sd;
      bus.burst_len = len;
      @(negedge clk);
      bus.start     = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({bus.out_valid, bus.out_last, bus.busy, bus.done} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 0000", {bus.out_valid, bus.out_last, bus.busy, bus.done});
      end
      n_checks++;
      if (bus.out_data !== 8'h01) begin
         n_fail++;
         $display("FAIL reset_data: got %h want 01", bus.out_data);
      end
      n_checks++;
      if ({bus.aborted, bus.seed_fixup, bus.words_sent} !== 18'd0) begin
         n_fail++;
         $display("FAIL reset_status: got %b %b %0d want 0 0 0", bus.aborted, bus.seed_fixup, bus.words_sent);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      bus.out_ready = 1'b1;
      do_start(7'h01, 16'd8);
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if ({bus.out_valid, bus.out_last, bus.out_data} !== {1'b1, (i == 7), seq01[i]}) begin
            n_fail++;
            $display("FAIL basic_word%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                     i, bus.out_valid, bus.out_last, bus.out_data, (i == 7), seq01[i]);
         end
         @(negedge clk);
      end
      n_checks++;
      if ({bus.done, bus.busy, bus.out_valid, bus.words_sent} !== {3'b110, 16'd8}) begin
         n_fail++;
         $display("FAIL basic_done: got done=%b busy=%b v=%b ws=%0d want 1 1 0 8",
                  bus.done, bus.busy, bus.out_valid, bus.words_sent);
      end
      @(negedge clk);
      n_checks++;
      if ({bus.done, bus.busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL basic_idle: got done=%b busy=%b want 0 0", bus.done, bus.busy);
      end
   endtask

   task automatic test_full_period();
      logic [127:0] seen;
      logic [6:0]   model;
      int           errs;
      seen  = '0;
      model = 7'h01;
      errs  = 0;
      bus.out_ready = 1'b1;
      do_start(7'h01, 16'd127);
      for (int i = 0; i < 127; i++) begin
         if (!bus.out_valid || bus.out_data !== {model[6], model} || seen[bus.out_data[6:0]] ||
             bus.out_last !== (i == 126)) begin
            errs++;
         end
         seen[bus.out_data[6:0]] = 1'b1;
         model = lfsr_step(model);
         @(negedge clk);
      end
      n_checks++;
      if (errs !== 0) begin
         n_fail++;
         $display("FAIL period_words: got %0d bad/repeated words want 0", errs);
      end
      n_checks++;
      if ({bus.done, bus.out_data, bus.words_sent} !== {1'b1, 8'h01, 16'd127}) begin
         n_fail++;
         $display("FAIL period_end: got done=%b d=%h ws=%0d want 1 01 127",
                  bus.done, bus.out_data, bus.words_sent);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic rdy [0:6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      int idx;
      int errs;
      idx  = 0;
      errs = 0;
      bus.out_ready = 1'b0;
      do_start(7'h01, 16'd4);
      for (int c = 0; c < 7; c++) begin
         bus.out_ready = rdy[c];
         if (!bus.out_valid || bus.out_data !== seq01[idx] || bus.out_last !== (idx == 3)) begin
            errs++;
            $display("FAIL bp_cycle%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                     c, bus.out_valid, bus.out_data, bus.out_last, seq01[idx], (idx == 3));
         end
         if (rdy[c]) idx++;
         @(negedge clk);
      end
      n_checks++;
      if (errs !== 0) n_fail++;
      n_checks++;
      if ({bus.done, bus.out_valid, bus.words_sent} !== {2'b10, 16'd4}) begin
         n_fail++;
         $display("FAIL bp_done: got done=%b v=%b ws=%0d want 1 0 4", bus.done, bus.out_valid, bus.words_sent);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_seed_zero();
      bus.out_ready = 1'b1;
      do_start(7'h00, 16'd2);
      n_checks++;
      if ({bus.seed_fixup, bus.out_data} !== {1'b1, 8'h01}) begin
         n_fail++;
         $display("FAIL seed0_first: got fix=%b d=%h want 1 01", bus.seed_fixup, bus.out_data);
      end
      @(negedge clk);
      n_checks++;
      if ({bus.out_last, bus.out_data} !== {1'b1, 8'h02}) begin
         n_fail++;
         $display("FAIL seed0_second: got l=%b d=%h want 1 02", bus.out_last, bus.out_data);
      end
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.seed_fixup !== 1'b1) begin
         n_fail++;
         $display("FAIL seed0_sticky: got %b want 1", bus.seed_fixup);
      end
      do_start(7'h05, 16'd1);
      n_checks++;
      if ({bus.seed_fixup, bus.out_data, bus.out_last} !== {1'b0, 8'h05, 1'b1}) begin
         n_fail++;
         $display("FAIL seed5: got fix=%b d=%h l=%b want 0 05 1", bus.seed_fixup, bus.out_data, bus.out_last);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_zero_len();
      do_start(7'h03, 16'd0);
      n_checks++;
      if ({bus.done, bus.busy, bus.out_valid, bus.words_sent} !== {3'b110, 16'd0}) begin
         n_fail++;
         $display("FAIL zlen_done: got done=%b busy=%b v=%b ws=%0d want 1 1 0 0",
                  bus.done, bus.busy, bus.out_valid, bus.words_sent);
      end
      // A start presented during DONE must be dropped.
      bus.start     = 1'b1;
      bus.burst_len = 16'd3;
      @(negedge clk);
      bus.start = 1'b0;
      n_checks++;
      if ({bus.done, bus.busy, bus.out_valid} !== 3'b000) begin
         n_fail++;
         $display("FAIL zlen_after: got done=%b busy=%b v=%b want 0 0 0", bus.done, bus.busy, bus.out_valid);
      end
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL start_in_done_ignored: got v=%b want 0", bus.out_valid);
      end
   endtask

   task automatic test_abort();
      bus.out_ready = 1'b1;
      do_start(7'h01, 16'd10);
      repeat (2) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      n_checks++;
      if ({bus.done, bus.aborted, bus.out_valid, bus.words_sent} !== {3'b110, 16'd3}) begin
         n_fail++;
         $display("FAIL abort_mid: got done=%b ab=%b v=%b ws=%0d want 1 1 0 3",
                  bus.done, bus.aborted, bus.out_valid, bus.words_sent);
      end
      @(negedge clk);
      // Abort coincident with the final handshake: normal completion wins.
      do_start(7'h01, 16'd2);
      @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      n_checks++;
      if ({bus.done, bus.aborted, bus.words_sent} !== {2'b10, 16'd2}) begin
         n_fail++;
         $display("FAIL abort_last: got done=%b ab=%b ws=%0d want 1 0 2", bus.done, bus.aborted, bus.words_sent);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bus.out_ready = 1'b1;
      do_start(7'h01, 16'd10);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_checks++;
      if ({bus.out_valid, bus.out_last, bus.busy, bus.done, bus.out_data, bus.words_sent} !==
          {4'b0000, 8'h01, 16'd0}) begin
         n_fail++;
         $display("FAIL rst_mid: got v=%b l=%b busy=%b done=%b d=%h ws=%0d want 0 0 0 0 01 0",
                  bus.out_valid, bus.out_last, bus.busy, bus.done, bus.out_data, bus.words_sent);
      end
      @(negedge clk);
      n_checks++;
      if ({bus.done, bus.busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL rst_mid_nodone: got done=%b busy=%b want 0 0", bus.done, bus.busy);
      end
   endtask

   task automatic test_start_during_run();
      int errs;
      errs = 0;
      bus.out_ready = 1'b0;
      do_start(7'h01, 16'd4);
      bus.start     = 1'b1;
      bus.seed      = 7'h33;
      bus.burst_len = 16'd2;
      @(negedge clk);
      bus.start     = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (!bus.out_valid || bus.out_data !== seq01[i] || bus.out_last !== (i == 3)) begin
            errs++;
            $display("FAIL busy_start_word%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                     i, bus.out_valid, bus.out_data, bus.out_last, seq01[i], (i == 3));
         end
         @(negedge clk);
      end
      n_checks++;
      if (errs !== 0) n_fail++;
      n_checks++;
      if ({bus.done, bus.words_sent} !== {1'b1, 16'd4}) begin
         n_fail++;
         $display("FAIL busy_start_done: got done=%b ws=%0d want 1 4", bus.done, bus.words_sent);
      end
      @(negedge clk);
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.seed      = 7'h00;
      bus.burst_len = 16'd0;
      bus.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_full_period();
      test_backpressure();
      test_seed_zero();
      test_zero_len();
      test_abort();
      test_reset_mid();
      test_start_during_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
